// File: rtl/line_refill_responder.sv
// line_refill_responder: memory-side responder for cache line refills.
// Line reads are answered with a burst of one line's words, starting at the
// critical word and wrapping (or starting at word 0 when WRAP=0).
// Single-word byte-masked writes are answered with one ack beat.
`timescale 1ns/1ps
module line_refill_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 5,
    parameter int MEM_AW     = 12,
    parameter int LATENCY    = 3,
    parameter int WRAP       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wr,
    input  logic [3:0]              req_wstrb,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic                    resp_last,
    output logic [BLOCK_SIZE-3:0]   resp_word_idx
);

    localparam int NB = BLOCK_SIZE - 2;
    localparam int LW = MEM_AW - NB;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

    state_t          state_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic            resp_last_q;
    logic [31:0]     resp_data_q;
    logic [NB-1:0]   resp_idx_q;
    logic [NB-1:0]   crit_q;
    logic [NB-1:0]   beat_q;
    logic [LW-1:0]   line_q;
    logic [3:0]      count_q;

    logic [31:0]     mem [0:(1<<MEM_AW)-1];

    logic [MEM_AW-1:0] reqWord;
    logic              accept;
    logic              respFire;
    logic [NB-1:0]     beat_d;
    logic [NB-1:0]     firstIdx;
    logic [NB-1:0]     nextIdx;
    logic              unused_addr;

    // Word index aliases modulo the array size; the byte lane and upper bits are dropped.
    assign reqWord     = req_addr[MEM_AW+1:2];
    assign unused_addr = ^{req_addr[ADDR_WIDTH-1:MEM_AW+2], req_addr[1:0]};
    assign accept      = (state_q == IDLE) && req_ready_q && req_valid;
    assign respFire    = resp_valid_q && resp_ready;

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_last     = resp_last_q;
    assign resp_data     = resp_data_q;
    assign resp_word_idx = resp_idx_q;

    // Burst index arithmetic: the N-bit add wraps naturally within the line.
    always_comb begin
        beat_d   = beat_q + 1'b1;
        firstIdx = (WRAP != 0) ? crit_q : '0;
        nextIdx  = (WRAP != 0) ? (crit_q + beat_d) : beat_d;
    end

    // Backing array: byte-masked write lands on the accept edge, so a later read sees it.
    always_ff @(posedge clk) begin
        if (accept && req_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    mem[reqWord][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered outputs; the beat register reloads only on a handshake,
    // which keeps data, index and last stable while the requester stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_data_q  <= '0;
            resp_idx_q   <= '0;
            crit_q       <= '0;
            beat_q       <= '0;
            line_q       <= '0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (req_wr) begin
                            state_q      <= WACK;
                            resp_valid_q <= 1'b1;
                            resp_last_q  <= 1'b1;
                            resp_data_q  <= '0;
                            resp_idx_q   <= reqWord[NB-1:0];
                        end else begin
                            state_q <= WAIT;
                            line_q  <= reqWord[MEM_AW-1:NB];
                            crit_q  <= reqWord[NB-1:0];
                            beat_q  <= '0;
                            count_q <= 4'(LATENCY);
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (count_q == 4'd0) begin
                        state_q      <= BURST;
                        resp_valid_q <= 1'b1;
                        resp_idx_q   <= firstIdx;
                        resp_data_q  <= mem[{line_q, firstIdx}];
                        resp_last_q  <= (beat_q == {NB{1'b1}});
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                BURST: begin
                    if (respFire) begin
                        if (resp_last_q) begin
                            state_q      <= IDLE;
                            resp_valid_q <= 1'b0;
                            resp_last_q  <= 1'b0;
                            resp_data_q  <= '0;
                            resp_idx_q   <= '0;
                        end else begin
                            beat_q      <= beat_d;
                            resp_idx_q  <= nextIdx;
                            resp_data_q <= mem[{line_q, nextIdx}];
                            resp_last_q <= (beat_d == {NB{1'b1}});
                        end
                    end
                end
                WACK: begin
                    if (respFire) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_last_q  <= 1'b0;
                        resp_data_q  <= '0;
                        resp_idx_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_refill_responder.sv
// tb_line_refill_responder: directed bench for line_refill_responder.
// Two instances share every input: one wraps from the critical word, one starts at word 0.
`timescale 1ns/1ps
module tb_line_refill_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        reqReadyW, respValidW, respLastW;
    logic [31:0] respDataW;
    logic [2:0]  respIdxW;
    logic        reqReadyF, respValidF, respLastF;
    logic [31:0] respDataF;
    logic [2:0]  respIdxF;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [0:4095];

    // Free-running clock
    always #5 clk = ~clk;

    line_refill_responder #(.WRAP(1)) dutWrap (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(reqReadyW), .req_addr(req_addr),
        .req_wr(req_wr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .resp_valid(respValidW), .resp_ready(resp_ready), .resp_data(respDataW),
        .resp_last(respLastW), .resp_word_idx(respIdxW)
    );

    line_refill_responder #(.WRAP(0)) dutFlat (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(reqReadyF), .req_addr(req_addr),
        .req_wr(req_wr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .resp_valid(respValidF), .resp_ready(resp_ready), .resp_data(respDataF),
        .resp_last(respLastF), .resp_word_idx(respIdxF)
    );

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady;
        int n;
        n = 0;
        while (!reqReadyW && n < 50) begin
            tick();
            n++;
        end
        checkOutput("req_ready reached", 32'(reqReadyW), 32'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        logic [11:0] w;
        waitReady();
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        req_wr    = 1'b1;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        req_wr    = 1'b0;
        w = addr[13:2];
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[w][8*b +: 8] = data[8*b +: 8];
        end
        n = 0;
        while (!respValidW && n < 10) begin
            tick();
            n++;
        end
        checkOutput("wack valid", 32'(respValidW), 32'd1);
        checkOutput("wack valid flat", 32'(respValidF), 32'd1);
        checkOutput("wack last", 32'(respLastW), 32'd1);
        checkOutput("wack data", respDataW, 32'd0);
        checkOutput("wack idx", 32'(respIdxW), 32'(addr[4:2]));
        tick();
        checkOutput("wack done", 32'(respValidW), 32'd0);
    endtask

    // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: hold req_valid through burst; 3: reset at beat 3
    task automatic readLine(input logic [31:0] addr, input int mode);
        logic [11:0] w;
        logic [8:0]  line;
        logic [2:0]  crit, idxW, idxF;
        int n, k, c, guard;
        logic hs;
        w    = addr[13:2];
        crit = w[2:0];
        line = w[11:3];
        waitReady();
        req_addr   = addr;
        req_wr     = 1'b0;
        req_valid  = 1'b1;
        resp_ready = (mode != 1);
        tick();
        if (mode != 2) req_valid = 1'b0;
        n = 0;
        while (!respValidW && n < 20) begin
            tick();
            n++;
        end
        checkOutput("first beat latency", 32'(n), 32'd4);
        k = 0; c = 0; guard = 0;
        while (k < 8 && guard < 100) begin
            idxW = crit + 3'(k);
            idxF = 3'(k);
            checkOutput("beat valid", 32'(respValidW), 32'd1);
            if (respValidW) begin
                checkOutput("wrap idx", 32'(respIdxW), 32'(idxW));
                checkOutput("wrap data", respDataW, model[{line, idxW}]);
                checkOutput("wrap last", 32'(respLastW), 32'(k == 7));
                checkOutput("flat valid", 32'(respValidF), 32'd1);
                checkOutput("flat idx", 32'(respIdxF), 32'(idxF));
                checkOutput("flat data", respDataF, model[{line, idxF}]);
                checkOutput("flat last", 32'(respLastF), 32'(k == 7));
                if (mode == 2) checkOutput("req_ready in burst", 32'(reqReadyW), 32'd0);
            end
            if (mode == 3 && k == 3) begin
                reset = 1'b1;
                #1;
                checkOutput("reset drops valid", 32'(respValidW), 32'd0);
                checkOutput("reset drops valid flat", 32'(respValidF), 32'd0);
                checkOutput("reset drops last", 32'(respLastW), 32'd0);
                checkOutput("reset req_ready", 32'(reqReadyW), 32'd0);
                tick();
                tick();
                reset = 1'b0;
                checkOutput("req_ready at release", 32'(reqReadyW), 32'd0);
                tick();
                checkOutput("req_ready after release", 32'(reqReadyW), 32'd1);
                checkOutput("no beat after reset", 32'(respValidW), 32'd0);
                return;
            end
            if (mode == 1) resp_ready = ((c % 4) == 0) || ((c % 4) == 3);
            c++;
            hs = respValidW && resp_ready;
            tick();
            guard++;
            if (hs) k++;
        end
        checkOutput("beat count", 32'(k), 32'd8);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        checkOutput("valid low after last", 32'(respValidW), 32'd0);
    endtask

    // Watchdog in case the DUT wedges in a way the bounded loops miss
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    // Directed sequence
    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0;
        req_wstrb = '0; req_wdata = '0; resp_ready = 1'b1;
        for (int i = 0; i < 4096; i++) model[i] = 32'd0;
        tick();
        tick();
        checkOutput("reset req_ready", 32'(reqReadyW), 32'd0);
        checkOutput("reset resp_valid", 32'(respValidW), 32'd0);
        checkOutput("reset resp_last", 32'(respLastW), 32'd0);
        checkOutput("reset resp_data", respDataW, 32'd0);
        checkOutput("reset resp_idx", 32'(respIdxW), 32'd0);
        checkOutput("reset resp_valid flat", 32'(respValidF), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("idle req_ready", 32'(reqReadyW), 32'd1);
        checkOutput("idle req_ready flat", 32'(reqReadyF), 32'd1);

        for (int i = 0; i < 16; i++) applyStimulus(32'(i * 4), 32'(i * 4), 4'hF);
        applyStimulus(32'h20, 32'h11223344, 4'hF);

        $display("[TB] critical-word-first read of 0x14");
        readLine(32'h14, 0);

        $display("[TB] partial write then read of 0x20");
        applyStimulus(32'h20, 32'hAABBCCDD, 4'b0101);
        readLine(32'h20, 0);
        checkOutput("merged word constant", model[8], 32'h11BB33DD);

        $display("[TB] zero-strobe write is acked but changes nothing");
        applyStimulus(32'h24, 32'hFFFFFFFF, 4'b0000);
        readLine(32'h24, 0);

        $display("[TB] stalled read");
        readLine(32'h0C, 1);

        $display("[TB] reset mid-burst then clean read");
        readLine(32'h18, 3);
        readLine(32'h18, 0);

        $display("[TB] aliased read with req_valid held");
        readLine(32'h0000_4008, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
